// File: rtl/assoc_cache_pkg.sv
// Shared types for the set-associative cache.
// Contents:
//   state_t : controller states for lookup, miss handling and flush.
package assoc_cache_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        WRITEBACK,
        FILL,
        RESPOND,
        FLUSH_SCAN,
        FLUSH_WB
    } state_t;

endpackage

// File: rtl/assoc_cache_lru.sv
// True-LRU bookkeeping for one set (purely combinational).
// Every way holds an age counter: 0 = most recently used, WAYS-1 = least.
// Ports:
//   counters      in  : current age counters of the set
//   valid         in  : valid bits of the set
//   access_way    in  : way being accessed
//   counters_next out : counters after touching access_way
//   victim        out : lowest-index invalid way, else the oldest way
module cache_lru #(
    parameter int WAYS = 4,
    localparam int WB  = $clog2(WAYS)
) (
    input  logic [WAYS-1:0][WB-1:0] counters,
    input  logic [WAYS-1:0]         valid,
    input  logic [WB-1:0]           access_way,
    output logic [WAYS-1:0][WB-1:0] counters_next,
    output logic [WB-1:0]           victim
);

    // Ways younger than the accessed one age by one; the accessed way
    // becomes youngest. Counters stay a permutation of 0..WAYS-1.
    always_comb begin
        counters_next = counters;
        for (int w = 0; w < WAYS; w++) begin
            if (w == int'(access_way)) begin
                counters_next[w] = '0;
            end else if (counters[w] < counters[access_way]) begin
                counters_next[w] = counters[w] + 1'b1;
            end
        end
    end

    // Descending scans so the lowest matching index wins; an invalid way
    // always takes precedence over the oldest valid way.
    always_comb begin
        victim = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (counters[w] == WB'(WAYS - 1)) begin
                victim = WB'(w);
            end
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid[w]) begin
                victim = WB'(w);
            end
        end
    end

endmodule

// File: rtl/assoc_cache.sv
// Set-associative, write-back, write-allocate cache with true-LRU
// replacement and whole-cache flush. Transfers whole lines to the next
// memory level over a req/ack handshake.
// Ports:
//   clock, reset                     : clock, synchronous active-high reset
//   cpu_req/we/addr/wdata            : requester command (taken when cpu_ready)
//   cpu_ready, cpu_valid, cpu_rdata  : idle flag, completion pulse, read data
//   flush, flush_done                : write back all dirty lines / done pulse
//   mem_req/we/addr/wdata            : next-level line request (held until ack)
//   mem_rdata, mem_ack               : next-level fill data and completion
module assoc_cache
    import assoc_cache_pkg::*;
#(
    parameter int SETS      = 64,
    parameter int WAYS      = 4,
    parameter int LINEWORDS = 8,
    parameter int WORDW     = 32,
    parameter int ADDRW     = 32
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       cpu_req,
    input  logic                       cpu_we,
    input  logic [ADDRW-1:0]           cpu_addr,
    input  logic [WORDW-1:0]           cpu_wdata,
    output logic                       cpu_ready,
    output logic                       cpu_valid,
    output logic [WORDW-1:0]           cpu_rdata,
    input  logic                       flush,
    output logic                       flush_done,
    output logic                       mem_req,
    output logic                       mem_we,
    output logic [ADDRW-1:0]           mem_addr,
    output logic [LINEWORDS*WORDW-1:0] mem_wdata,
    input  logic [LINEWORDS*WORDW-1:0] mem_rdata,
    input  logic                       mem_ack
);

    localparam int OB = $clog2(LINEWORDS);
    localparam int SB = $clog2(SETS);
    localparam int WB = $clog2(WAYS);
    localparam int TW = ADDRW - OB - SB;
    localparam int LW = LINEWORDS * WORDW;
    localparam int FB = SB + WB;

    function automatic logic [WORDW-1:0] line_word(input logic [LW-1:0] line,
                                                   input logic [OB-1:0] off);
        return line[off*WORDW +: WORDW];
    endfunction

    function automatic logic [WAYS-1:0][WB-1:0] lru_init();
        logic [WAYS-1:0][WB-1:0] c;
        for (int w = 0; w < WAYS; w++) begin
            c[w] = WB'(w);
        end
        return c;
    endfunction

    // Line storage: control bits packed per set, tags and data per line.
    logic [SETS-1:0][WAYS-1:0]         valid_q;
    logic [SETS-1:0][WAYS-1:0]         dirty_q;
    logic [SETS-1:0][WAYS-1:0][WB-1:0] lru_q;
    logic [TW-1:0]                     tag_q  [SETS][WAYS];
    logic [LW-1:0]                     data_q [SETS][WAYS];

    state_t              state;
    logic                req_we;
    logic [ADDRW-1:0]    req_addr;
    logic [WORDW-1:0]    req_wdata;
    logic [WB-1:0]       way_q;
    logic [FB-1:0]       flush_idx;

    logic [OB-1:0]       req_off;
    logic [SB-1:0]       req_set;
    logic [TW-1:0]       req_tag;
    logic [SB-1:0]       f_set;
    logic [WB-1:0]       f_way;

    assign req_off = req_addr[OB-1:0];
    assign req_set = req_addr[OB+SB-1:OB];
    assign req_tag = req_addr[ADDRW-1:OB+SB];
    // Flush walks (set, way) with the way in the low bits so it runs fastest.
    assign f_set   = flush_idx[FB-1:WB];
    assign f_way   = flush_idx[WB-1:0];

    assign cpu_ready = (state == IDLE);
    assign cpu_valid = (state == RESPOND);

    logic          hit;
    logic [WB-1:0] hit_way;

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[req_set][w] && (tag_q[req_set][w] == req_tag)) begin
                hit     = 1'b1;
                hit_way = WB'(w);
            end
        end
    end

    logic [WAYS-1:0][WB-1:0] lru_next;
    logic [WB-1:0]           victim;

    cache_lru #(.WAYS(WAYS)) u_lru (
        .counters      (lru_q[req_set]),
        .valid         (valid_q[req_set]),
        .access_way    (way_q),
        .counters_next (lru_next),
        .victim        (victim)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            valid_q    <= '0;
            dirty_q    <= '0;
            lru_q      <= {SETS{lru_init()}};
            flush_idx  <= '0;
            flush_done <= 1'b0;
            cpu_rdata  <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            flush_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (flush) begin
                        flush_idx <= '0;
                        state     <= FLUSH_SCAN;
                    end else if (cpu_req) begin
                        req_we    <= cpu_we;
                        req_addr  <= cpu_addr;
                        req_wdata <= cpu_wdata;
                        state     <= LOOKUP;
                    end
                end

                LOOKUP: begin
                    if (hit) begin
                        way_q     <= hit_way;
                        cpu_rdata <= line_word(data_q[req_set][hit_way], req_off);
                        state     <= RESPOND;
                    end else begin
                        way_q   <= victim;
                        mem_req <= 1'b1;
                        if (valid_q[req_set][victim] && dirty_q[req_set][victim]) begin
                            mem_we    <= 1'b1;
                            mem_addr  <= {tag_q[req_set][victim], req_set, {OB{1'b0}}};
                            mem_wdata <= data_q[req_set][victim];
                            state     <= WRITEBACK;
                        end else begin
                            mem_we   <= 1'b0;
                            mem_addr <= {req_tag, req_set, {OB{1'b0}}};
                            state    <= FILL;
                        end
                    end
                end

                WRITEBACK: begin
                    // Keep mem_req high and retarget it straight to the fill.
                    if (mem_ack) begin
                        mem_we   <= 1'b0;
                        mem_addr <= {req_tag, req_set, {OB{1'b0}}};
                        state    <= FILL;
                    end
                end

                FILL: begin
                    if (mem_ack) begin
                        mem_req                <= 1'b0;
                        data_q[req_set][way_q] <= mem_rdata;
                        tag_q[req_set][way_q]  <= req_tag;
                        valid_q[req_set][way_q] <= 1'b1;
                        dirty_q[req_set][way_q] <= 1'b0;
                        cpu_rdata              <= line_word(mem_rdata, req_off);
                        state                  <= RESPOND;
                    end
                end

                RESPOND: begin
                    // cpu_rdata already holds the pre-write word.
                    if (req_we) begin
                        data_q[req_set][way_q][req_off*WORDW +: WORDW] <= req_wdata;
                        dirty_q[req_set][way_q] <= 1'b1;
                    end
                    lru_q[req_set] <= lru_next;
                    state          <= IDLE;
                end

                FLUSH_SCAN: begin
                    if (valid_q[f_set][f_way] && dirty_q[f_set][f_way]) begin
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= {tag_q[f_set][f_way], f_set, {OB{1'b0}}};
                        mem_wdata <= data_q[f_set][f_way];
                        state     <= FLUSH_WB;
                    end else if (flush_idx == '1) begin
                        flush_done <= 1'b1;
                        state      <= IDLE;
                    end else begin
                        flush_idx <= flush_idx + 1'b1;
                    end
                end

                FLUSH_WB: begin
                    if (mem_ack) begin
                        mem_req               <= 1'b0;
                        mem_we                <= 1'b0;
                        dirty_q[f_set][f_way] <= 1'b0;
                        if (flush_idx == '1) begin
                            flush_done <= 1'b1;
                            state      <= IDLE;
                        end else begin
                            flush_idx <= flush_idx + 1'b1;
                            state     <= FLUSH_SCAN;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_assoc_cache.sv
// Self-checking bench for assoc_cache (SETS=4, WAYS=2, LINEWORDS=4,
// WORDW=32, ADDRW=16). A backing memory answers line requests; a flat
// reference memory predicts read data and writeback contents.
module tb_assoc_cache;

    logic         clk = 1'b0;
    logic         reset;
    logic         cpu_req, cpu_we;
    logic [15:0]  cpu_addr;
    logic [31:0]  cpu_wdata;
    logic         cpu_ready, cpu_valid;
    logic [31:0]  cpu_rdata;
    logic         flush, flush_done;
    logic         mem_req, mem_we;
    logic [15:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ack;

    assoc_cache #(
        .SETS(4), .WAYS(2), .LINEWORDS(4), .WORDW(32), .ADDRW(16)
    ) dut (
        .clock(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_ready(cpu_ready), .cpu_valid(cpu_valid),
        .cpu_rdata(cpu_rdata), .flush(flush), .flush_done(flush_done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [15:0] addr;
    } mem_txn_t;

    mem_txn_t    exp_mem[$];
    logic [31:0] exp_cpu[$];
    logic [31:0] bmem    [0:65535];
    logic [31:0] ref_mem [0:65535];
    int          ack_delay = 2;
    int          total = 0;
    int          bad = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] ref_line(input logic [15:0] a);
        logic [127:0] l;
        for (int i = 0; i < 4; i++) l[i*32 +: 32] = ref_mem[a + 16'(i)];
        return l;
    endfunction

    task automatic exp_fill(input logic [15:0] a);
        exp_mem.push_back('{we: 1'b0, addr: a});
    endtask

    task automatic exp_wb(input logic [15:0] a);
        exp_mem.push_back('{we: 1'b1, addr: a});
    endtask

    // Next-level memory: logs each new request against the scoreboard,
    // checks the request stays stable while waiting, then acks.
    initial begin : responder
        int           cnt;
        logic         cap_we;
        logic [15:0]  cap_addr;
        logic [127:0] cap_wdata;
        mem_txn_t     e;
        cnt = 0;
        mem_ack = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (mem_req !== 1'b1) begin
                cnt = 0;
            end else begin
                if (cnt == 0) begin
                    cap_we = mem_we; cap_addr = mem_addr; cap_wdata = mem_wdata;
                    if (exp_mem.size() == 0) begin
                        check("mem_unexpected_req", 128'(exp_mem.size()), 128'd1);
                    end else begin
                        e = exp_mem.pop_front();
                        check("mem_we", 128'(mem_we), 128'(e.we));
                        check("mem_addr", 128'(mem_addr), 128'(e.addr));
                        if (mem_we) check("mem_wdata", mem_wdata, ref_line(mem_addr));
                    end
                    cnt = 1;
                end else begin
                    check("hold_we", 128'(mem_we), 128'(cap_we));
                    check("hold_addr", 128'(mem_addr), 128'(cap_addr));
                    check("hold_wdata", mem_wdata, cap_wdata);
                    cnt++;
                end
                if (cnt >= ack_delay) begin
                    for (int i = 0; i < 4; i++) begin
                        if (mem_we) bmem[mem_addr + 16'(i)] = mem_wdata[i*32 +: 32];
                        else mem_rdata[i*32 +: 32] = bmem[mem_addr + 16'(i)];
                    end
                    mem_ack = 1'b1;
                    cnt = 0;
                end
            end
        end
    end

    // Completion monitor: pops the expected read data on every cpu_valid.
    initial begin : cpu_monitor
        forever begin
            @(negedge clk);
            if (cpu_valid === 1'b1) begin
                if (exp_cpu.size() == 0) check("cpu_unexpected_valid", 128'(exp_cpu.size()), 128'd1);
                else check("cpu_rdata", 128'(cpu_rdata), 128'(exp_cpu.pop_front()));
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (cpu_ready !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (cpu_ready !== 1'b1) check("ready_timeout", 128'(cpu_ready), 128'd1);
    endtask

    // exp_lat > 0 checks cycles from accept edge to the cpu_valid cycle.
    task automatic cpu_op(input logic we, input logic [15:0] a, input logic [31:0] wd,
                          input int exp_lat);
        int n;
        wait_ready();
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
        exp_cpu.push_back(ref_mem[a]);
        if (we) ref_mem[a] = wd;
        @(posedge clk);
        #1 cpu_req = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (cpu_valid !== 1'b1 && n < 500);
        if (cpu_valid !== 1'b1) check("valid_timeout", 128'(cpu_valid), 128'd1);
        else if (exp_lat > 0) check("latency", 128'(n), 128'(exp_lat));
    endtask

    task automatic do_flush(output int n);
        wait_ready();
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (flush_done !== 1'b1 && n < 500);
        check("flush_done", 128'(flush_done), 128'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; cpu_req = 1'b0; flush = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_cpu_ready", 128'(cpu_ready), 128'd1);
        check("rst_cpu_valid", 128'(cpu_valid), 128'd0);
        check("rst_mem_req", 128'(mem_req), 128'd0);
        check("rst_flush_done", 128'(flush_done), 128'd0);
        reset = 1'b0;
        // Dirty lines are lost on reset; the reference follows the backing store.
        for (int a = 0; a < 65536; a++) ref_mem[a] = bmem[a];
    endtask

    initial begin : main
        int n;
        reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0;
        cpu_wdata = '0; flush = 1'b0;
        for (int a = 0; a < 65536; a++) bmem[a] = 32'(a + 12);

        // Cold miss then hit in the same line.
        do_reset();
        check("rst_cpu_rdata", 128'(cpu_rdata), 128'd0);
        check("rst_mem_addr", 128'(mem_addr), 128'd0);
        exp_fill(16'h0004);
        cpu_op(1'b0, 16'h0005, 32'h0, 4);
        check("cold_word", 128'(cpu_rdata), 128'h11);
        cpu_op(1'b0, 16'h0006, 32'h0, 2);
        check("hit_word", 128'(cpu_rdata), 128'h12);

        // Dirty victim is written back before the fill.
        do_reset();
        exp_fill(16'h0000);
        cpu_op(1'b1, 16'h0001, 32'hDEADBEEF, 4);
        exp_fill(16'h0010);
        cpu_op(1'b0, 16'h0010, 32'h0, 4);
        exp_wb(16'h0000);
        exp_fill(16'h0020);
        cpu_op(1'b0, 16'h0020, 32'h0, 6);
        check("wb_word1", 128'(bmem[16'h0001]), 128'hDEADBEEF);

        // LRU picks the least recently used clean line.
        do_reset();
        exp_fill(16'h0000);
        cpu_op(1'b0, 16'h0000, 32'h0, 4);
        exp_fill(16'h0010);
        cpu_op(1'b0, 16'h0010, 32'h0, 4);
        cpu_op(1'b0, 16'h0000, 32'h0, 2);
        exp_fill(16'h0020);
        cpu_op(1'b0, 16'h0020, 32'h0, 4);
        cpu_op(1'b0, 16'h0000, 32'h0, 2);

        // Flush writes dirty lines in ascending set order; second flush is a pure scan.
        do_reset();
        exp_fill(16'h0004);
        cpu_op(1'b1, 16'h0005, 32'hA1A1A1A1, 0);
        exp_fill(16'h0008);
        cpu_op(1'b0, 16'h0009, 32'h0, 0);
        exp_fill(16'h000C);
        cpu_op(1'b1, 16'h000E, 32'hC3C3C3C3, 0);
        exp_wb(16'h0004);
        exp_wb(16'h000C);
        do_flush(n);
        check("flush_wb_drained", 128'(exp_mem.size()), 128'd0);
        do_flush(n);
        check("flush2_cycles", 128'(n), 128'd9);
        check("flush_bmem3", 128'(bmem[16'h000E]), 128'hC3C3C3C3);

        // Writeback held off by a slow next level.
        do_reset();
        exp_fill(16'h0000);
        cpu_op(1'b1, 16'h0002, 32'h5A5A0002, 0);
        exp_fill(16'h0010);
        cpu_op(1'b0, 16'h0010, 32'h0, 0);
        ack_delay = 11;
        exp_wb(16'h0000);
        exp_fill(16'h0020);
        cpu_op(1'b0, 16'h0020, 32'h0, 0);
        ack_delay = 2;

        // Reset during a fill abandons it and loses cached lines.
        do_reset();
        exp_fill(16'h0004);
        cpu_op(1'b0, 16'h0005, 32'h0, 4);
        ack_delay = 1000;
        exp_fill(16'h0008);
        wait_ready();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0008;
        @(posedge clk);
        #1 cpu_req = 1'b0;
        n = 0;
        while (mem_req !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("fill_started", 128'(mem_req), 128'd1);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_fill_mem_req", 128'(mem_req), 128'd0);
        reset = 1'b0;
        for (int a = 0; a < 65536; a++) ref_mem[a] = bmem[a];
        @(negedge clk);
        check("rst_fill_ready", 128'(cpu_ready), 128'd1);
        check("rst_fill_mem_req2", 128'(mem_req), 128'd0);
        ack_delay = 2;
        exp_fill(16'h0004);
        cpu_op(1'b0, 16'h0005, 32'h0, 4);

        repeat (4) @(negedge clk);
        check("mem_q_left", 128'(exp_mem.size()), 128'd0);
        check("cpu_q_left", 128'(exp_cpu.size()), 128'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
